multiplexer_4to1: RTL and testbench

//  - 4-to-1 selector: two select bits {a,b} route one of four data inputs i0..i3 to result.
//  - Lab-level datapath primitive; also usable as a leaf mux in larger select trees.
//  - result is purely combinational (zero latency).
//  - result_q is a registered copy for callers that need a clocked output.

---
 rtl/multiplexer_4to1_pkg.sv | 12 +
 rtl/multiplexer_4to1.sv | 50 +++++
 tb/tb_multiplexer_4to1.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/multiplexer_4to1_pkg.sv
// Shared select encoding for the 4:1 lab mux.
// sel = {a,b}; each code names the data input it routes.
package multiplexer_4to1_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_I0 = 2'd0;
  localparam sel_t SEL_I1 = 2'd1;
  localparam sel_t SEL_I2 = 2'd2;
  localparam sel_t SEL_I3 = 2'd3;

endpackage

// File: rtl/multiplexer_4to1.sv
// 4:1 selector with a zero-latency combinational output and a registered copy.
// {a,b} selects i0..i3; result_q clears asynchronously on rst.
module multiplexer_4to1
  import multiplexer_4to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_q
);

  sel_t             sel;
  logic [WIDTH-1:0] hold_d;
  logic [WIDTH-1:0] hold_q;

  assign sel = {a, b};

  // The default arm only fires on X/Z selects, so simulation shows all-X
  // while synthesis sees a full binary case with no latch.
  always_comb begin
    case (sel)
      SEL_I0:  result = i0;
      SEL_I1:  result = i1;
      SEL_I2:  result = i2;
      SEL_I3:  result = i3;
      default: result = 'x;
    endcase
  end

  assign hold_d = result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign result_q = hold_q;

endmodule

// File: tb/tb_multiplexer_4to1.sv
// Directed and exhaustive bench for multiplexer_4to1 at WIDTH=1 and WIDTH=8.
// Combinational result checked from a vector table; result_q checked around clock edges and reset.
module tb_multiplexer_4to1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       a1, b1;
  logic [0:0] i0_1, i1_1, i2_1, i3_1;
  logic [0:0] res1, resq1;

  logic       a8, b8;
  logic [7:0] i0_8, i1_8, i2_8, i3_8;
  logic [7:0] res8, resq8;

  multiplexer_4to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1),
    .i0(i0_1), .i1(i1_1), .i2(i2_1), .i3(i3_1),
    .result(res1), .result_q(resq1)
  );

  multiplexer_4to1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8),
    .i0(i0_8), .i1(i1_8), .i2(i2_8), .i3(i3_8),
    .result(res8), .result_q(resq8)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive1(input logic sa, input logic sb, input logic [3:0] d);
    a1 = sa; b1 = sb;
    i0_1 = d[0]; i1_1 = d[1]; i2_1 = d[2]; i3_1 = d[3];
  endtask

  task automatic drive8(input logic sa, input logic sb,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
    a8 = sa; b8 = sb;
    i0_8 = d0; i1_8 = d1; i2_8 = d2; i3_8 = d3;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic       a;
    logic       b;
    logic [3:0] d;   // {i3,i2,i1,i0}
    logic       exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] d8[4];
    logic [3:0] dv;
    logic [1:0] s;
    logic [7:0] e;

    vecs[0] = '{"i0_sel_one",    1'b0, 1'b0, 4'b0001, 1'b1};
    vecs[1] = '{"i0_sel_zero",   1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[2] = '{"i1_sel_one",    1'b0, 1'b1, 4'b0010, 1'b1};
    vecs[3] = '{"i1_all_zero",   1'b0, 1'b1, 4'b0000, 1'b0};
    vecs[4] = '{"i2_sel_one",    1'b1, 1'b0, 4'b0100, 1'b1};
    vecs[5] = '{"i2_iso_i1",     1'b1, 1'b0, 4'b0010, 1'b0};
    vecs[6] = '{"i3_sel_one",    1'b1, 1'b1, 4'b1000, 1'b1};
    vecs[7] = '{"i3_iso_i1",     1'b1, 1'b1, 4'b0010, 1'b0};
    vecs[8] = '{"i0_iso_others", 1'b0, 1'b0, 4'b1110, 1'b0};
    vecs[9] = '{"i3_iso_others", 1'b1, 1'b1, 4'b0111, 1'b0};

    // Reset state
    rst = 1'b1;
    drive1(1'b0, 1'b0, 4'b0000);
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    #2;
    check("reset_resq1", 32'(resq1), 32'h0);
    check("reset_resq8", 32'(resq8), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, combinational path
    foreach (vecs[k]) begin
      drive1(vecs[k].a, vecs[k].b, vecs[k].d);
      #1;
      check(vecs[k].name, 32'(res1), 32'(vecs[k].exp));
    end

    // Exhaustive WIDTH=1: expected taken by bit-indexing the data nibble
    for (int n = 0; n < 64; n++) begin
      s  = n[5:4];
      dv = n[3:0];
      drive1(s[1], s[0], dv);
      #1;
      check("exh_w1", 32'(res1), 32'(dv[s]));
    end

    // Random data WIDTH=8, every select code covered
    for (int n = 0; n < 32; n++) begin
      for (int j = 0; j < 4; j++) d8[j] = 8'($urandom_range(0, 255));
      s = n[1:0];
      drive8(s[1], s[0], d8[0], d8[1], d8[2], d8[3]);
      #1;
      check("rand_w8", 32'(res8), 32'(d8[s]));
    end

    // Registered path: exactly one cycle of latency
    @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      for (int j = 0; j < 4; j++) d8[j] = 8'($urandom_range(0, 255));
      s = 2'($urandom_range(0, 3));
      drive8(s[1], s[0], d8[0], d8[1], d8[2], d8[3]);
      exp_q.push_back(d8[s]);
      #1;
      if (n > 0) check("resq8_before_edge", 32'(resq8), 32'(exp_q[0]));
      if (n > 0) void'(exp_q.pop_front());
      @(posedge clk);
      #1;
      check("resq8_after_edge", 32'(resq8), 32'(exp_q[0]));
      @(negedge clk);
    end
    exp_q.delete();

    // Load a 1 into result_q, then assert reset between edges
    drive1(1'b1, 1'b1, 4'b1000);
    @(posedge clk);
    #1;
    check("resq1_loaded", 32'(resq1), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_resq1", 32'(resq1), 32'h0);
    check("async_rst_resq8", 32'(resq8), 32'h0);
    @(posedge clk);
    #1;
    check("rst_held_resq1", 32'(resq1), 32'h0);

    // Release reset; result_q must wait for the next rising edge
    @(negedge clk);
    rst = 1'b0;
    drive1(1'b1, 1'b1, 4'b1000);
    #1;
    check("post_rst_wait", 32'(resq1), 32'h0);
    check("post_rst_comb", 32'(res1), 32'h1);
    @(posedge clk);
    #1;
    check("post_rst_one_edge", 32'(resq1), 32'h1);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
